// File: rtl/multi_sprite_display.sv
// VGA timing generator with NUM_SPRITES solid tiles; SPRITE_COLLISION_EN adds a sticky overlap flag.
// Syncs/colour registered (1 clk after counters); sprite writes always accepted, no backpressure.
module multi_sprite_display #(
    parameter int H_VISIBLE_AREA = 640,
    parameter int H_FRONT_PORCH  = 16,
    parameter int H_SYNC_PULSE   = 96,
    parameter int H_BACK_PORCH   = 48,
    parameter int V_VISIBLE_AREA = 480,
    parameter int V_FRONT_PORCH  = 10,
    parameter int V_SYNC_PULSE   = 2,
    parameter int V_BACK_PORCH   = 33,
    parameter int TILE_SIZE      = 16,
    parameter int NUM_SPRITES    = 4,
    parameter int COLOR_BITS     = 3
) (
    input  logic                                               i_Clk,
    input  logic                                               i_Rst_L,
    input  logic                                               i_Wr_En,
    input  logic [((NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1)-1:0] i_Wr_Idx,
    input  logic [9:0]                                         i_Wr_X,
    input  logic [9:0]                                         i_Wr_Y,
    input  logic [3*COLOR_BITS-1:0]                            i_Wr_Color,
    input  logic                                               i_Wr_Visible,
    output logic                                               o_VGA_HSync,
    output logic                                               o_VGA_VSync,
    output logic [COLOR_BITS-1:0]                              o_VGA_Red,
    output logic [COLOR_BITS-1:0]                              o_VGA_Grn,
    output logic [COLOR_BITS-1:0]                              o_VGA_Blu,
    output logic                                               o_Frame_Start,
    output logic                                               o_Collision
);
    localparam int H_TOTAL = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int V_TOTAL = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int IW      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int CW      = 3 * COLOR_BITS;

    typedef struct packed {
        logic          vis;
        logic [10:0]   x;
        logic [10:0]   y;
        logic [CW-1:0] col;
    } sprite_t;

    logic [HW-1:0]  h_q, h_d;
    logic [VW-1:0]  v_q, v_d;
    logic           hs_q, hs_d, vs_q, vs_d, fs_q;
    logic [CW-1:0]  pix_q, pix_d;
    sprite_t        shadow_q [NUM_SPRITES];
    sprite_t        shadow_d [NUM_SPRITES];
    sprite_t        active_q [NUM_SPRITES];
    sprite_t        active_d [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] hit;
    logic           copy_cycle, in_vis;
    logic [11:0]    hx, vy;

    // Keeps a tile fully on screen, computed in 11 bits so X up to 1023 cannot wrap.
    function automatic logic [10:0] clamp_pos(input logic [10:0] p, input int lim);
        if (p + 11'(TILE_SIZE) > 11'(lim)) begin
            return 11'(lim - TILE_SIZE);
        end
        return p;
    endfunction

    assign hx         = 12'(h_q);
    assign vy         = 12'(v_q);
    assign copy_cycle = (h_q == '0) && (v_q == VW'(V_VISIBLE_AREA));
    assign in_vis     = (hx < 12'(H_VISIBLE_AREA)) && (vy < 12'(V_VISIBLE_AREA));

    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == HW'(H_TOTAL - 1)) begin
            h_d = '0;
            v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
        end
    end

    always_comb begin
        hs_d = !((hx >= 12'(H_VISIBLE_AREA + H_FRONT_PORCH)) &&
                 (hx <  12'(H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE)));
        vs_d = !((vy >= 12'(V_VISIBLE_AREA + V_FRONT_PORCH)) &&
                 (vy <  12'(V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE)));
    end

    // A write coinciding with the copy lands in shadow only; active takes the pre-write shadow.
    always_comb begin
        for (int k = 0; k < NUM_SPRITES; k++) begin
            shadow_d[k] = shadow_q[k];
            if (i_Wr_En && (i_Wr_Idx == IW'(k))) begin
                shadow_d[k].vis = i_Wr_Visible;
                shadow_d[k].x   = {1'b0, i_Wr_X};
                shadow_d[k].y   = {1'b0, i_Wr_Y};
                shadow_d[k].col = i_Wr_Color;
            end
            active_d[k] = active_q[k];
            if (copy_cycle) begin
                active_d[k].vis = shadow_q[k].vis;
                active_d[k].x   = clamp_pos(shadow_q[k].x, H_VISIBLE_AREA);
                active_d[k].y   = clamp_pos(shadow_q[k].y, V_VISIBLE_AREA);
                active_d[k].col = shadow_q[k].col;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_SPRITES; k++) begin
            hit[k] = in_vis && active_q[k].vis &&
                     (hx >= {1'b0, active_q[k].x}) && (hx < {1'b0, active_q[k].x} + 12'(TILE_SIZE)) &&
                     (vy >= {1'b0, active_q[k].y}) && (vy < {1'b0, active_q[k].y} + 12'(TILE_SIZE));
        end
    end

    // Descending scan so the lowest-index hit is the last assignment.
    always_comb begin
        pix_d = '0;
        for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
            if (hit[k]) begin
                pix_d = active_q[k].col;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            h_q   <= '0;
            v_q   <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            pix_q <= '0;
            fs_q  <= 1'b0;
            for (int k = 0; k < NUM_SPRITES; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            pix_q <= pix_d;
            fs_q  <= copy_cycle;
            for (int k = 0; k < NUM_SPRITES; k++) begin
                shadow_q[k] <= shadow_d[k];
                active_q[k] <= active_d[k];
            end
        end
    end

`ifdef SPRITE_COLLISION_EN
    logic coll_q, coll_d, multi_hit, seen_hit;

    always_comb begin
        multi_hit = 1'b0;
        seen_hit  = 1'b0;
        for (int k = 0; k < NUM_SPRITES; k++) begin
            if (hit[k]) begin
                multi_hit = multi_hit | seen_hit;
                seen_hit  = 1'b1;
            end
        end
        coll_d = multi_hit | (coll_q & ~copy_cycle);
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            coll_q <= 1'b0;
        end else begin
            coll_q <= coll_d;
        end
    end

    assign o_Collision = coll_q;
`else
    assign o_Collision = 1'b0;
`endif

    assign o_VGA_HSync   = hs_q;
    assign o_VGA_VSync   = vs_q;
    assign o_VGA_Red     = pix_q[CW-1 -: COLOR_BITS];
    assign o_VGA_Grn     = pix_q[2*COLOR_BITS-1 -: COLOR_BITS];
    assign o_VGA_Blu     = pix_q[COLOR_BITS-1:0];
    assign o_Frame_Start = fs_q;

endmodule

// File: tb/tb_multi_sprite_display.sv
// Randomised and directed checks of multi_sprite_display against a pixel-index reference model.
module tb_multi_sprite_display;
    localparam int HV = 32, HF = 2, HS = 4, HB = 2;
    localparam int VV = 24, VF = 2, VS = 2, VB = 2;
    localparam int T = 4, NS = 3, CB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FR = HT * VT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_idx = '0;
    logic [9:0] wr_x = '0, wr_y = '0;
    logic [8:0] wr_col = '0;
    logic       wr_vis = 1'b0;
    logic       o_hs, o_vs, o_fs, o_coll;
    logic [2:0] o_r, o_g, o_b;
    logic [8:0] dut_rgb;

    multi_sprite_display #(
        .H_VISIBLE_AREA(HV), .H_FRONT_PORCH(HF), .H_SYNC_PULSE(HS), .H_BACK_PORCH(HB),
        .V_VISIBLE_AREA(VV), .V_FRONT_PORCH(VF), .V_SYNC_PULSE(VS), .V_BACK_PORCH(VB),
        .TILE_SIZE(T), .NUM_SPRITES(NS), .COLOR_BITS(CB)
    ) dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Wr_En(wr_en), .i_Wr_Idx(wr_idx),
        .i_Wr_X(wr_x), .i_Wr_Y(wr_y), .i_Wr_Color(wr_col), .i_Wr_Visible(wr_vis),
        .o_VGA_HSync(o_hs), .o_VGA_VSync(o_vs), .o_VGA_Red(o_r), .o_VGA_Grn(o_g),
        .o_VGA_Blu(o_b), .o_Frame_Start(o_fs), .o_Collision(o_coll)
    );

    assign dut_rgb = {o_r, o_g, o_b};
    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;

    // Reference model: m_h/m_v is the pixel the DUT counters present this cycle;
    // e_* are the outputs the DUT must show after the coming edge, e_h/e_v their pixel.
    int   s_x[NS], s_y[NS], s_c[NS], a_x[NS], a_y[NS], a_c[NS];
    bit   s_v[NS], a_v[NS];
    int   m_h = 0, m_v = 0, e_h = -1, e_v = -1;
    logic e_hs = 1'b1, e_vs = 1'b1, e_fs = 1'b0, e_coll = 1'b0;
    logic [8:0] e_rgb = '0;

    always @(posedge clk) begin
        int hits;
        int col;
        bit copy;
        if (!rst_n) begin
            for (int k = 0; k < NS; k++) begin
                s_x[k] = 0; s_y[k] = 0; s_c[k] = 0; s_v[k] = 0;
                a_x[k] = 0; a_y[k] = 0; a_c[k] = 0; a_v[k] = 0;
            end
            m_h = 0; m_v = 0; e_h = -1; e_v = -1;
            e_hs = 1'b1; e_vs = 1'b1; e_rgb = '0; e_fs = 1'b0; e_coll = 1'b0;
        end else begin
            e_h  = m_h;
            e_v  = m_v;
            e_hs = !(m_h >= HV + HF && m_h < HV + HF + HS);
            e_vs = !(m_v >= VV + VF && m_v < VV + VF + VS);
            hits = 0;
            col  = 0;
            if (m_h < HV && m_v < VV) begin
                for (int k = 0; k < NS; k++) begin
                    if (a_v[k] && m_h >= a_x[k] && m_h < a_x[k] + T && m_v >= a_y[k] && m_v < a_y[k] + T) begin
                        if (hits == 0) col = a_c[k];
                        hits++;
                    end
                end
            end
            e_rgb = 9'(col);
            copy  = (m_h == 0 && m_v == VV);
            e_fs  = copy;
`ifdef SPRITE_COLLISION_EN
            e_coll = (hits >= 2) || (e_coll && !copy);
`else
            e_coll = 1'b0;
`endif
            if (copy) begin
                for (int k = 0; k < NS; k++) begin
                    a_v[k] = s_v[k];
                    a_c[k] = s_c[k];
                    a_x[k] = (s_x[k] + T > HV) ? HV - T : s_x[k];
                    a_y[k] = (s_y[k] + T > VV) ? VV - T : s_y[k];
                end
            end
            if (wr_en && int'(wr_idx) < NS) begin
                s_x[wr_idx] = int'(wr_x); s_y[wr_idx] = int'(wr_y);
                s_c[wr_idx] = int'(wr_col); s_v[wr_idx] = wr_vis;
            end
            m_h = m_h + 1;
            if (m_h == HT) begin
                m_h = 0;
                m_v = (m_v + 1) % VT;
            end
        end
    end

    task automatic wr(input int idx, input int x, input int y, input int c, input bit vis);
        wr_en = 1'b1; wr_idx = 2'(idx); wr_x = 10'(x); wr_y = 10'(y); wr_col = 9'(c); wr_vis = vis;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_fs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < FR + 5 && !ok; i++) begin
            @(negedge clk);
            if (o_fs === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        wr(0, 5, 5, 9'h1FF, 1'b1);
        repeat (4) begin
            @(negedge clk);
            n_cmp++; if ({o_hs, o_vs} !== 2'b11) begin n_err++; $display("FAIL reset_sync got %b exp 11", {o_hs, o_vs}); end
            n_cmp++; if (dut_rgb !== 9'h000) begin n_err++; $display("FAIL reset_rgb got %h exp 000", dut_rgb); end
            n_cmp++; if ({o_fs, o_coll} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b exp 00", {o_fs, o_coll}); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_blank_frame();
        int hs_low = 0, vs_low = 0, fs_cnt = 0, lit = 0;
        repeat (FR) begin
            @(negedge clk);
            n_cmp++; if ({o_hs, o_vs} !== {e_hs, e_vs}) begin n_err++; $display("FAIL blank_sync got %b exp %b", {o_hs, o_vs}, {e_hs, e_vs}); end
            n_cmp++; if (dut_rgb !== e_rgb) begin n_err++; $display("FAIL blank_rgb got %h exp %h", dut_rgb, e_rgb); end
            n_cmp++; if ({o_fs, o_coll} !== {e_fs, e_coll}) begin n_err++; $display("FAIL blank_flags got %b exp %b", {o_fs, o_coll}, {e_fs, e_coll}); end
            if (o_hs === 1'b0) hs_low++;
            if (o_vs === 1'b0) vs_low++;
            if (o_fs === 1'b1) fs_cnt++;
            if (dut_rgb !== 9'h000) lit++;
        end
        n_cmp++; if (hs_low != HS * VT) begin n_err++; $display("FAIL blank_hs_low got %0d exp %0d", hs_low, HS * VT); end
        n_cmp++; if (vs_low != VS * HT) begin n_err++; $display("FAIL blank_vs_low got %0d exp %0d", vs_low, VS * HT); end
        n_cmp++; if (fs_cnt != 1) begin n_err++; $display("FAIL blank_fs_count got %0d exp 1", fs_cnt); end
        n_cmp++; if (lit != 0) begin n_err++; $display("FAIL blank_lit got %0d exp 0", lit); end
    endtask

    task automatic test_sprite(input string tag, input int x, input int y, input int ex, input int ey);
        bit ok;
        int lit = 0, minh = 9999, minv = 9999;
        wr(0, x, y, 9'h1FF, 1'b1);
        wr(1, 1000, 1000, 9'h038, 1'b1);
        wr(2, 0, 0, 0, 1'b0);
        wait_fs(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL %s_fs_timeout got 0 exp 1", tag); end
        repeat (FR) begin
            @(negedge clk);
            n_cmp++; if ({o_hs, o_vs} !== {e_hs, e_vs}) begin n_err++; $display("FAIL %s_sync got %b exp %b", tag, {o_hs, o_vs}, {e_hs, e_vs}); end
            n_cmp++; if (dut_rgb !== e_rgb) begin n_err++; $display("FAIL %s_rgb got %h exp %h at %0d,%0d", tag, dut_rgb, e_rgb, e_h, e_v); end
            n_cmp++; if ({o_fs, o_coll} !== {e_fs, e_coll}) begin n_err++; $display("FAIL %s_flags got %b exp %b", tag, {o_fs, o_coll}, {e_fs, e_coll}); end
            if (dut_rgb === 9'h1FF) begin
                lit++;
                if (e_h < minh) minh = e_h;
                if (e_v < minv) minv = e_v;
            end
        end
        n_cmp++; if (lit != T * T) begin n_err++; $display("FAIL %s_lit got %0d exp %0d", tag, lit, T * T); end
        n_cmp++; if (minh != ex || minv != ey) begin n_err++; $display("FAIL %s_origin got %0d,%0d exp %0d,%0d", tag, minh, minv, ex, ey); end
    endtask

    task automatic test_overlap();
        bit ok;
        int red = 0, blue = 0, ch = -1, cv = -1;
        wr(0, 12, 12, 9'h1C0, 1'b1);
        wr(1, 12, 12, 9'h007, 1'b1);
        wait_fs(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL overlap_fs_timeout got 0 exp 1"); end
        wr(1, 2, 2, 9'h007, 1'b1);
        repeat (FR - 1) begin
            @(negedge clk);
            n_cmp++; if (dut_rgb !== e_rgb) begin n_err++; $display("FAIL overlap_rgb got %h exp %h at %0d,%0d", dut_rgb, e_rgb, e_h, e_v); end
            n_cmp++; if ({o_fs, o_coll} !== {e_fs, e_coll}) begin n_err++; $display("FAIL overlap_flags got %b exp %b", {o_fs, o_coll}, {e_fs, e_coll}); end
            if (dut_rgb === 9'h1C0) red++;
            if (dut_rgb === 9'h007) blue++;
            if (o_coll === 1'b1 && ch < 0) begin ch = e_h; cv = e_v; end
        end
        n_cmp++; if (red != T * T || blue != 0) begin n_err++; $display("FAIL overlap_priority got red %0d blue %0d exp %0d 0", red, blue, T * T); end
`ifdef SPRITE_COLLISION_EN
        n_cmp++; if (ch != 12 || cv != 12) begin n_err++; $display("FAIL overlap_first_coll got %0d,%0d exp 12,12", ch, cv); end
`else
        n_cmp++; if (ch != -1) begin n_err++; $display("FAIL overlap_coll_tied got %0d exp -1", ch); end
`endif
        red = 0; blue = 0; ch = -1;
        repeat (FR + 2) begin
            @(negedge clk);
            n_cmp++; if (dut_rgb !== e_rgb) begin n_err++; $display("FAIL moved_rgb got %h exp %h at %0d,%0d", dut_rgb, e_rgb, e_h, e_v); end
            n_cmp++; if ({o_fs, o_coll} !== {e_fs, e_coll}) begin n_err++; $display("FAIL moved_flags got %b exp %b", {o_fs, o_coll}, {e_fs, e_coll}); end
            if (dut_rgb === 9'h1C0) red++;
            if (dut_rgb === 9'h007) blue++;
            if (o_coll === 1'b1 && e_v < VV) ch = e_v;
        end
        n_cmp++; if (red != T * T || blue != T * T) begin n_err++; $display("FAIL moved_counts got red %0d blue %0d exp %0d %0d", red, blue, T * T, T * T); end
        n_cmp++; if (ch != -1) begin n_err++; $display("FAIL moved_coll_cleared got line %0d exp -1", ch); end
    endtask

    task automatic test_write_in_copy();
        bit ok, found;
        int old_lit, new_lit;
        wr(1, 0, 0, 0, 1'b0);
        wr(0, 20, 6, 9'h1FF, 1'b1);
        wait_fs(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL copywr_fs_timeout got 0 exp 1"); end
        found = 1'b0;
        for (int i = 0; i < FR + 5 && !found; i++) begin
            @(negedge clk);
            if (m_h == 0 && m_v == VV) found = 1'b1;
        end
        n_cmp++; if (!found) begin n_err++; $display("FAIL copywr_locate got 0 exp 1"); end
        wr(0, 4, 4, 9'h1FF, 1'b1);
        for (int f = 0; f < 2; f++) begin
            old_lit = 0; new_lit = 0;
            repeat (FR) begin
                @(negedge clk);
                n_cmp++; if (dut_rgb !== e_rgb) begin n_err++; $display("FAIL copywr_rgb got %h exp %h at %0d,%0d", dut_rgb, e_rgb, e_h, e_v); end
                if (dut_rgb === 9'h1FF && e_h >= 20) old_lit++;
                if (dut_rgb === 9'h1FF && e_h < 8) new_lit++;
            end
            n_cmp++; if (old_lit != ((f == 0) ? T * T : 0)) begin n_err++; $display("FAIL copywr_old_f%0d got %0d exp %0d", f, old_lit, (f == 0) ? T * T : 0); end
            n_cmp++; if (new_lit != ((f == 0) ? 0 : T * T)) begin n_err++; $display("FAIL copywr_new_f%0d got %0d exp %0d", f, new_lit, (f == 0) ? 0 : T * T); end
        end
    endtask

    task automatic test_random();
        repeat (3 * FR) begin
            @(negedge clk);
            n_cmp++; if ({o_hs, o_vs} !== {e_hs, e_vs}) begin n_err++; $display("FAIL rand_sync got %b exp %b", {o_hs, o_vs}, {e_hs, e_vs}); end
            n_cmp++; if (dut_rgb !== e_rgb) begin n_err++; $display("FAIL rand_rgb got %h exp %h at %0d,%0d", dut_rgb, e_rgb, e_h, e_v); end
            n_cmp++; if ({o_fs, o_coll} !== {e_fs, e_coll}) begin n_err++; $display("FAIL rand_flags got %b exp %b", {o_fs, o_coll}, {e_fs, e_coll}); end
            wr_en = ($urandom_range(0, 29) == 0);
            if (wr_en) begin
                wr_idx = 2'($urandom_range(0, 3));
                wr_x   = 10'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 36));
                wr_y   = 10'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 28));
                wr_col = 9'($urandom_range(1, 511));
                wr_vis = ($urandom_range(0, 3) != 0);
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset_midframe();
        bit found = 1'b0;
        int first_low = -1, lit = 0;
        for (int i = 0; i < FR + 5 && !found; i++) begin
            @(negedge clk);
            if (m_v == VV / 2) found = 1'b1;
        end
        n_cmp++; if (!found) begin n_err++; $display("FAIL midrst_locate got 0 exp 1"); end
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_cmp++; if ({o_hs, o_vs, o_fs, o_coll} !== 4'b1100 || dut_rgb !== 9'h000) begin
                n_err++; $display("FAIL midrst_values got %b/%h exp 1100/000", {o_hs, o_vs, o_fs, o_coll}, dut_rgb);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < FR; i++) begin
            @(negedge clk);
            n_cmp++; if ({o_hs, o_vs} !== {e_hs, e_vs}) begin n_err++; $display("FAIL midrst_sync got %b exp %b", {o_hs, o_vs}, {e_hs, e_vs}); end
            n_cmp++; if ({o_fs, o_coll} !== {e_fs, e_coll}) begin n_err++; $display("FAIL midrst_flags got %b exp %b", {o_fs, o_coll}, {e_fs, e_coll}); end
            if (o_hs === 1'b0 && first_low < 0) first_low = i;
            if (dut_rgb !== 9'h000) lit++;
        end
        n_cmp++; if (first_low != HV + HF) begin n_err++; $display("FAIL midrst_restart got %0d exp %0d", first_low, HV + HF); end
        n_cmp++; if (lit != 0) begin n_err++; $display("FAIL midrst_cleared got %0d exp 0", lit); end
    endtask

    initial begin
        test_reset();
        test_blank_frame();
        test_sprite("basic", 10, 6, 10, 6);
        test_sprite("clamp", 30, 22, 28, 20);
        test_overlap();
        test_write_in_copy();
        test_random();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
